// File: rtl/jtdd_sdram_sched.sv
// jtdd_sdram_sched: four-slot SDRAM read scheduler, each slot with a one-entry read cache.
// Define JTDD_SCHED_RR_EN for round-robin arbitration; without it, slot0 has the highest priority.
//
// state | meaning
// IDLE  | no transfer in flight; grant a pending slot unless downloading
// REQ   | sdram_req held high until sdram_ack
// WAIT  | request accepted; wait for data_rdy, bounded by the watchdog
module jtdd_sdram_sched #(
  parameter int AW       = 22,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slot0_cs,
  input  logic          slot1_cs,
  input  logic          slot2_cs,
  input  logic          slot3_cs,
  input  logic [AW-1:0] slot0_addr,
  input  logic [AW-1:0] slot1_addr,
  input  logic [AW-1:0] slot2_addr,
  input  logic [AW-1:0] slot3_addr,
  output logic          slot0_ok,
  output logic          slot1_ok,
  output logic          slot2_ok,
  output logic          slot3_ok,
  output logic [DW-1:0] slot0_dout,
  output logic [DW-1:0] slot1_dout,
  output logic [DW-1:0] slot2_dout,
  output logic [DW-1:0] slot3_dout,
  input  logic          downloading,
  output logic          sdram_req,
  output logic [AW-1:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [DW-1:0] data_read
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0] WD_LOAD = WW'(WAIT_MAX - 1);

  logic [3:0]    cs;
  logic [AW-1:0] slot_addr [4];
  logic [3:0]    ok;
  logic [3:0]    pend;
  logic [1:0]    gnt;

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    gslot_q, gslot_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [3:0]    valid_q, valid_d;
  logic [AW-1:0] tag_q [4];
  logic [AW-1:0] tag_d [4];
  logic [DW-1:0] data_q [4];
  logic [DW-1:0] data_d [4];

  assign cs = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
  assign slot_addr[0] = slot0_addr;
  assign slot_addr[1] = slot1_addr;
  assign slot_addr[2] = slot2_addr;
  assign slot_addr[3] = slot3_addr;

  // Hit is purely combinational so an address change drops ok in the same cycle.
  always_comb begin
    ok = '0;
    for (int i = 0; i < 4; i++) begin
      ok[i] = cs[i] & valid_q[i] & (tag_q[i] == slot_addr[i]);
    end
  end

  assign pend = cs & ~ok;

`ifdef JTDD_SCHED_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;
  logic       found;

  // Search begins one past the last granted slot and wraps around.
  always_comb begin
    gnt   = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && pend[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt = '0;
    for (int k = 3; k >= 0; k--) begin
      if (pend[k]) gnt = 2'(k);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    gslot_d = gslot_q;
    wd_d    = wd_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
`ifdef JTDD_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    if (downloading) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      valid_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pend) begin
            gslot_d = gnt;
            addr_d  = slot_addr[gnt];
            req_d   = 1'b1;
            state_d = ST_REQ;
`ifdef JTDD_SCHED_RR_EN
            ptr_d   = gnt;
`endif
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            req_d   = 1'b0;
            wd_d    = WD_LOAD;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The fill uses the latched address, whatever the slot is doing now.
          if (data_rdy) begin
            tag_d[gslot_q]   = addr_q;
            data_d[gslot_q]  = data_read;
            valid_d[gslot_q] = 1'b1;
            state_d          = ST_IDLE;
          end else if (wd_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            wd_d = wd_q - WW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      gslot_q <= '0;
      wd_q    <= '0;
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
`ifdef JTDD_SCHED_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      gslot_q <= gslot_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
`ifdef JTDD_SCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign sdram_req  = req_q & ~downloading;
  assign sdram_addr = addr_q;

  assign slot0_ok   = ok[0];
  assign slot1_ok   = ok[1];
  assign slot2_ok   = ok[2];
  assign slot3_ok   = ok[3];
  assign slot0_dout = data_q[0];
  assign slot1_dout = data_q[1];
  assign slot2_dout = data_q[2];
  assign slot3_dout = data_q[3];

endmodule

// File: tb/tb_jtdd_sdram_sched.sv
// Bench for jtdd_sdram_sched: transaction-level cache/arbiter model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jtdd_sdram_sched;

  localparam int AW       = 22;
  localparam int DW       = 32;
  localparam int WAIT_MAX = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    cs = '0;
  logic [AW-1:0] addr [4];
  logic          downloading = 1'b0;
  logic          sdram_ack = 1'b0;
  logic          data_rdy = 1'b0;
  logic [DW-1:0] data_read = '0;
  wire  [3:0]    ok_w;
  wire  [DW-1:0] dout [4];
  wire           sdram_req;
  wire  [AW-1:0] sdram_addr;

  int tests = 0;
  int fails = 0;

  jtdd_sdram_sched #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .slot0_cs(cs[0]), .slot1_cs(cs[1]), .slot2_cs(cs[2]), .slot3_cs(cs[3]),
    .slot0_addr(addr[0]), .slot1_addr(addr[1]), .slot2_addr(addr[2]), .slot3_addr(addr[3]),
    .slot0_ok(ok_w[0]), .slot1_ok(ok_w[1]), .slot2_ok(ok_w[2]), .slot3_ok(ok_w[3]),
    .slot0_dout(dout[0]), .slot1_dout(dout[1]), .slot2_dout(dout[2]), .slot3_dout(dout[3]),
    .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-slot cache contents plus the one outstanding transfer.
  logic [3:0]    m_valid;
  logic [AW-1:0] m_tag [4];
  logic [DW-1:0] m_data [4];
  logic          busy, accepted, newg, exp_req;
  int            wcnt, gslot, last_g;
  logic [AW-1:0] gaddr;
  logic [3:0]    exp_ok;
  logic [3:0]    p_pend;
  logic          p_ack, p_rdy, p_dl, p_idle;
  logic [DW-1:0] p_data;
  logic [AW-1:0] p_addr [4];

  function automatic int arb(input logic [3:0] pend, input int last);
`ifdef JTDD_SCHED_RR_EN
    for (int k = 1; k <= 4; k++) if (pend[(last + k) % 4]) return (last + k) % 4;
    return last;
`else
    for (int s = 0; s < 4; s++) if (pend[s]) return s;
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; accepted = 0; wcnt = 0; last_g = 0; gslot = 0; gaddr = '0;
      m_valid = '0;
      for (int i = 0; i < 4; i++) begin m_tag[i] = '0; m_data[i] = '0; p_addr[i] = '0; end
      p_pend = '0; p_ack = 0; p_rdy = 0; p_dl = 0; p_idle = 1; p_data = '0;
      chk("rst_ok", {60'd0, ok_w}, 64'd0);
      chk("rst_req", {63'd0, sdram_req}, 64'd0);
      chk("rst_addr", {42'd0, sdram_addr}, 64'd0);
      for (int i = 0; i < 4; i++) chk("rst_dout", {32'd0, dout[i]}, 64'd0);
    end else begin
      // Apply what the clock edge just taken must have done.
      if (p_dl) begin
        m_valid = '0; busy = 0; accepted = 0;
      end else if (busy && !accepted) begin
        if (p_ack) begin accepted = 1; wcnt = 0; end
      end else if (busy && accepted) begin
        if (p_rdy) begin
          m_tag[gslot] = gaddr; m_data[gslot] = p_data; m_valid[gslot] = 1'b1;
          busy = 0; accepted = 0;
        end else begin
          wcnt++;
          if (wcnt == WAIT_MAX) begin busy = 0; accepted = 0; end
        end
      end
      newg = p_idle && !p_dl && (p_pend != 4'd0);
      if (newg) begin
        gslot = arb(p_pend, last_g);
        gaddr = p_addr[gslot];
        last_g = gslot;
        busy = 1; accepted = 0;
      end
      exp_req = busy && !accepted && !downloading;
      chk("sdram_req", {63'd0, sdram_req}, {63'd0, exp_req});
      if (busy) chk("sdram_addr", {42'd0, sdram_addr}, {42'd0, gaddr});
      for (int i = 0; i < 4; i++) exp_ok[i] = cs[i] && m_valid[i] && (m_tag[i] == addr[i]);
      chk("slot_ok", {60'd0, ok_w}, {60'd0, exp_ok});
      for (int i = 0; i < 4; i++) if (exp_ok[i]) chk("slot_dout", {32'd0, dout[i]}, {32'd0, m_data[i]});
      p_pend = cs & ~exp_ok;
      p_ack = sdram_ack; p_rdy = data_rdy; p_dl = downloading; p_data = data_read;
      for (int i = 0; i < 4; i++) p_addr[i] = addr[i];
      p_idle = !busy;
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 40) begin tick(); n++; end
    chk("req_seen", {63'd0, sdram_req}, 64'd1);
  endtask

  task automatic serve(input int ack_dly, input int rdy_dly, input logic [DW-1:0] d,
                       input logic [AW-1:0] exp_addr);
    wait_req();
    chk("serve_addr", {42'd0, sdram_addr}, {42'd0, exp_addr});
    repeat (ack_dly) tick();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    repeat (rdy_dly) tick();
    data_read = d; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ord [4];
    int n;
    for (int i = 0; i < 4; i++) addr[i] = '0;
`ifdef JTDD_SCHED_RR_EN
    ord = '{2, 3, 0, 1};
`else
    ord = '{0, 1, 2, 3};
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single miss on slot2.
    cs[2] = 1'b1; addr[2] = 22'h28010;
    serve(1, 1, 32'hCAFEBABE, 22'h28010);
    chk("miss_ok", {63'd0, ok_w[2]}, 64'd1);
    chk("miss_dout", {32'd0, dout[2]}, 64'hCAFEBABE);

    // Hit: same address again, no request.
    cs[2] = 1'b0; tick(); tick();
    cs[2] = 1'b1; #1;
    chk("hit_ok", {63'd0, ok_w[2]}, 64'd1);
    chk("hit_dout", {32'd0, dout[2]}, 64'hCAFEBABE);
    for (int i = 0; i < 3; i++) begin tick(); chk("hit_no_req", {63'd0, sdram_req}, 64'd0); end

    // Address change drops ok in the same cycle.
    addr[2] = 22'h28011; #1;
    chk("addr_chg_ok", {63'd0, ok_w[2]}, 64'd0);
    serve(0, 0, 32'h11111111, 22'h28011);

    // Stray ack/data_rdy while idle are ignored.
    cs = '0;
    data_read = 32'hBAD0BAD0; data_rdy = 1'b1; sdram_ack = 1'b1; tick();
    data_rdy = 1'b0; sdram_ack = 1'b0; tick();
    cs[2] = 1'b1; #1;
    chk("stray_ok", {63'd0, ok_w[2]}, 64'd1);
    chk("stray_dout", {32'd0, dout[2]}, 64'h11111111);
    cs = '0;

    // Granted slot moves away mid-transfer; fill still uses the latched address.
    cs[1] = 1'b1; addr[1] = 22'h100;
    wait_req();
    cs[1] = 1'b0; addr[1] = 22'h200;
    serve(1, 2, 32'h0000_0100, 22'h100);
    cs[1] = 1'b1; addr[1] = 22'h100; #1;
    chk("moved_ok", {63'd0, ok_w[1]}, 64'd1);
    chk("moved_dout", {32'd0, dout[1]}, 64'h100);
    cs = '0; tick();

    // Contention: all four miss together.
    for (int i = 0; i < 4; i++) addr[i] = 22'h1000 + 22'(i);
    cs = 4'hF;
    for (int i = 0; i < 4; i++) serve(0, 0, 32'hD000_0000 | 32'(ord[i]), 22'h1000 + 22'(ord[i]));
    chk("cont_all_ok", {60'd0, ok_w}, 64'hF);
    for (int i = 0; i < 4; i++) chk("cont_dout", {32'd0, dout[i]}, 64'hD000_0000 | 64'(i));
    cs = '0; tick();

    // Watchdog: accepted but no data.
    cs[3] = 1'b1; addr[3] = 22'h3AAAA;
    wait_req();
    chk("wd_addr", {42'd0, sdram_addr}, 64'h3AAAA);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    n = 0;
    while (sdram_req !== 1'b1 && n < 400) begin tick(); n++; end
    chk("wd_cycles", 64'(n), 64'd256);
    chk("wd_readdr", {42'd0, sdram_addr}, 64'h3AAAA);
    serve(0, 0, 32'h3333_3333, 22'h3AAAA);
    chk("wd_fill_dout", {32'd0, dout[3]}, 64'h33333333);

    // Downloading during WAIT.
    addr[0] = 22'h5555; addr[1] = 22'h1001; addr[2] = 22'h1002;
    cs = 4'hF;
    wait_req();
    chk("dl_grant_addr", {42'd0, sdram_addr}, 64'h5555);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    downloading = 1'b1; #1;
    chk("dl_req_low", {63'd0, sdram_req}, 64'd0);
    tick();
    chk("dl_all_invalid", {60'd0, ok_w}, 64'd0);
    tick();
    cs = '0; tick();
    downloading = 1'b0;
    data_read = 32'hDEADDEAD; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    cs[1] = 1'b1; #1;
    chk("dl_rdy_ignored", {60'd0, ok_w}, 64'd0);
    serve(0, 0, 32'h0000_1001, 22'h1001);
    cs = '0; tick();

    // Reset in the middle of a transfer.
    cs[2] = 1'b1; addr[2] = 22'h7777;
    wait_req();
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    chk("rstmid_req", {63'd0, sdram_req}, 64'd0);
    chk("rstmid_addr", {42'd0, sdram_addr}, 64'd0);
    chk("rstmid_ok", {60'd0, ok_w}, 64'd0);
    tick();
    cs = '0; tick();
    rst_n = 1'b1; tick();
    data_read = 32'h7777_7777; data_rdy = 1'b1; tick(); data_rdy = 1'b0;
    cs[2] = 1'b1; #1;
    chk("rstmid_rdy_ignored", {63'd0, ok_w[2]}, 64'd0);
    serve(0, 0, 32'h0000_7777, 22'h7777);
    chk("rstmid_refill", {32'd0, dout[2]}, 64'h7777);
    cs = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
